// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiplier and restoring divider, both retiring one bit per cycle.
// While an operation runs, stall_req holds PC, IF/ID and ID/EX.
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [ACC_W-1:0]  acc_q, acc_d;       // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, done_q;

    logic              signed_a_c, signed_b_c, neg_c;
    logic [XLEN-1:0]   abs_a_c, abs_b_c;
    logic              div_zero_c, div_ovf_c;

    logic [XLEN:0]     mul_sum_c;
    logic [ACC_W-1:0]  mul_next_c;
    logic [XLEN:0]     div_rem_sh_c, div_diff_c;
    logic [ACC_W-1:0]  div_next_c;
    logic [ACC_W-1:0]  step_c, prod_c;
    logic [XLEN-1:0]   div_sel_c, div_res_c, final_c;

    // Operand decode at issue: signedness, magnitudes, result sign and special cases.
    always_comb begin
        signed_a_c = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
        signed_b_c = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        abs_a_c    = (signed_a_c && op_a[XLEN-1]) ? -op_a : op_a;
        abs_b_c    = (signed_b_c && op_b[XLEN-1]) ? -op_b : op_b;
        unique case (funct3)
            F3_MULH, F3_DIV:   neg_c = op_a[XLEN-1] ^ op_b[XLEN-1];
            F3_MULHSU, F3_REM: neg_c = op_a[XLEN-1];
            default:           neg_c = 1'b0;
        endcase
        div_zero_c = funct3[2] && (op_b == '0);
        div_ovf_c  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (op_a == MIN_NEG) && (op_b == ALL_ONES);
    end

    // One iteration step of the datapath plus the sign-fixed final result.
    always_comb begin
        mul_sum_c    = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next_c   = {mul_sum_c, acc_q[XLEN-1:1]};
        div_rem_sh_c = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
        div_diff_c   = div_rem_sh_c - {1'b0, opnd_q};
        // Borrow out of the trial subtraction means the divisor did not fit: restore.
        div_next_c   = div_diff_c[XLEN] ? {div_rem_sh_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                        : {div_diff_c[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
        step_c       = f3_q[2] ? div_next_c : mul_next_c;
        prod_c       = neg_q ? -step_c : step_c;
        div_sel_c    = f3_q[1] ? step_c[ACC_W-1:XLEN] : step_c[XLEN-1:0];
        div_res_c    = neg_q ? -div_sel_c : div_sel_c;
        if (f3_q[2]) begin
            final_c = div_res_c;
        end else if (f3_q[1:0] == 2'b00) begin
            final_c = prod_c[XLEN-1:0];
        end else begin
            final_c = prod_c[ACC_W-1:XLEN];
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    f3_d  = funct3;
                    neg_d = neg_c;
                    cnt_d = '0;
                    if (div_zero_c) begin
                        result_d = funct3[1] ? op_a : ALL_ONES;
                        state_d  = ST_DONE;
                    end else if (div_ovf_c) begin
                        result_d = funct3[1] ? '0 : MIN_NEG;
                        state_d  = ST_DONE;
                    end else begin
                        // Divider: dividend shifts out of lo; multiplier: |b| shifts out of lo.
                        opnd_d  = funct3[2] ? abs_b_c : abs_a_c;
                        acc_d   = funct3[2] ? {{XLEN{1'b0}}, abs_a_c} : {{XLEN{1'b0}}, abs_b_c};
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        result_d = final_c;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= (state_d == ST_CALC);
            done_q   <= (state_d == ST_DONE);
        end
    end

    // Stall is combinational so the accepting cycle already freezes the front end.
    assign stall_req = ((state_q == ST_IDLE) && start && !flush) || (state_q == ST_CALC);
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table plus flush/reset sequences.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Issue one instruction, hold start until done, check latency, stall and result.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        bit seen;
        bit stall_ok;
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; flush = 1'b0; start = 1'b1;
        #1 chk({nm, "_stall_accept"}, 32'(stall_req), 32'd1);
        n = 0; seen = 1'b0; stall_ok = 1'b1;
        while (!seen && n < 80) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            else if (!(stall_req && busy)) stall_ok = 1'b0;
        end
        chk({nm, "_stall_calc"}, 32'(stall_ok), 32'd1);
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
        chk({nm, "_result"}, result, exp_res);
        chk({nm, "_stall_at_done"}, {30'd0, stall_req, busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk({nm, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        tbl[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33}; // MUL 7*-3
        tbl[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33}; // MULH
        tbl[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33}; // MULHU
        tbl[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33}; // MULHSU
        tbl[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33}; // DIV -7/2
        tbl[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33}; // REM -7%2
        tbl[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33}; // DIVU
        tbl[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33}; // REMU
        tbl[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};  // DIVU /0
        tbl[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1};  // REM /0
        tbl[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};  // DIV ovf
        tbl[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};  // REM ovf
        tbl[12] = '{3'b001, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 33}; // MULH -3*5
        tbl[13] = '{3'b011, 32'h8000_0000, 32'd4,         32'd2,         33}; // MULHU
        tbl[14] = '{3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33}; // DIV 20/-3
        tbl[15] = '{3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         33}; // REM 20%-3
        tbl[16] = '{3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         33}; // DIV -7/-2
        tbl[17] = '{3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33}; // REM -7%-2
        tbl[18] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33}; // DIVU no ovf
        tbl[19] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33}; // REMU
        tbl[20] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33}; // DIVU /1
        tbl[21] = '{3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF, 1};  // DIV /0
        tbl[22] = '{3'b111, 32'h0000_DEAD, 32'd0,         32'h0000_DEAD, 1};  // REMU /0
        tbl[23] = '{3'b000, 32'd1000,      32'd1000,      32'd1000000,   33}; // MUL

        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
        #12;
        chk("reset_outputs", {29'd0, stall_req, busy, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("v%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
        end

        // start together with flush in IDLE is ignored.
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
        #1 chk("idle_flush_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_state", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        chk("idle_flush_nodone", {30'd0, busy, done}, 32'd0);
        chk("idle_flush_result", result, tbl[NV-1].exp);

        // DIV aborted by flush at T+10: no done, result unchanged, then a fresh MUL.
        @(negedge clk);
        funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1; flush = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) ndone++;
            if (k == 10) begin
                chk("flush_busy_before", 32'(busy), 32'd1);
                flush = 1'b1; start = 1'b0;
            end
        end
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_after", {30'd0, busy, stall_req}, 32'd0);
        chk("flush_result_kept", result, tbl[NV-1].exp);
        for (int k = 0; k < 3; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("flush_no_done", 32'(ndone), 32'd0);
        run_op("after_flush_mul", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // Reset in the middle of a MUL clears outputs and no stray done follows.
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        chk("midreset_busy_before", 32'(busy), 32'd1);
        reset = 1'b1; start = 1'b0;
        #1;
        chk("midreset_outputs", {29'd0, stall_req, busy, done}, 32'd0);
        chk("midreset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("midreset_quiet", 32'(ndone), 32'd0);
        chk("midreset_result_hold", result, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
